serial_sub: RTL
===============

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-004 Port start, input, 1 bit, SHALL request one subtraction; sampled on rising clk edges.
REQ-005 Port a, input, WIDTH bits, SHALL be the minuend (unsigned), sampled with start.
REQ-006 Port b, input, WIDTH bits, SHALL be the subtrahend (unsigned), sampled with start.
REQ-007 Port diff, output, WIDTH bits, SHALL be the registered result a-b modulo 2^WIDTH.
REQ-008 Port bor, output, 1 bit, SHALL be the registered final borrow (1 when a<b).
REQ-009 Port busy, output, 1 bit, SHALL be high while an operation is in progress.
REQ-010 Port done, output, 1 bit, SHALL be a one-cycle pulse marking diff/bor valid for a new result.

Function
REQ-011 The block SHALL compute the difference bit-serially, LSB first, one bit per clock, using a half/full-subtractor cell plus a borrow flip-flop.
REQ-012 Per bit: d = ai ^ bi ^ bin; bout = (~ai & bi) | (~(ai ^ bi) & bin); bin for bit 0 = 0.
REQ-013 The FSM SHALL have states IDLE, SHIFT, DONE; encoding is free.
REQ-014 IDLE: busy=0, done=0; on an edge with start=1, it SHALL latch a and b into shift registers, clear the borrow FF, load the bit counter with 0, and go to SHIFT.
REQ-015 SHIFT: busy=1; each edge SHALL process one bit, shift the operand registers right, shift d into the MSB of a result shift register, store bout, and increment the counter.
REQ-016 SHIFT SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1 it SHALL go to DONE.
REQ-017 On entering DONE, diff SHALL load the full result register and bor the final bout in the same edge.
REQ-018 DONE: busy=0, done=1 for exactly one cycle, then unconditionally go to IDLE.
REQ-019 Latency: if start is sampled at edge E0, done SHALL be high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 edges after start is sampled.
REQ-020 diff and bor SHALL hold their last values from one DONE until the next DONE; they SHALL NOT show partial results during SHIFT.
REQ-021 start SHALL be ignored in SHIFT and DONE; a and b changes outside IDLE-with-start SHALL have no effect.
REQ-022 start held high continuously SHALL launch a new operation on each return to IDLE (one IDLE cycle between operations).
REQ-023 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-024 rst=1 SHALL immediately, without a clock edge, force state IDLE, diff=0, bor=0, busy=0, done=0, and clear operand, result, borrow and counter registers.
REQ-025 rst asserted mid-operation SHALL abort it; no done pulse for the aborted operation after rst deasserts.
REQ-026 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-027 WIDTH=8, a=5, b=3, start pulse -> busy 8 cycles, done pulse on 9th edge after start, diff=2, bor=0.
REQ-028 a=3, b=5 -> diff=254 (8'hFE), bor=1; a=0, b=0 -> diff=0, bor=0; a=255, b=255 -> diff=0, bor=0.
REQ-029 a=0, b=1 -> diff=255, bor=1 (borrow ripples through all bits).
REQ-030 a=9, b=4 started, start pulsed again with a=1, b=2 at cycle 3 -> only one done, diff=5, bor=0; diff unchanged during SHIFT.
REQ-031 rst pulsed at cycle 4 of an operation -> all outputs 0 asynchronously, no done follows; next start with a=7, b=7 -> diff=0, bor=0.
REQ-032 start held high with a=6, b=2 -> done every 10 cycles, diff=4 each time, busy low in the DONE and IDLE cycles between operations.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: computes a - b LSB first, one bit per clock,
// using a full-subtractor cell and a borrow flip-flop, then presents the result.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bor,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bor_q, bor_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic d_bit;
  logic b_out;

  // Subtractor cell operates on the current LSBs and the stored borrow.
  always_comb begin
    d_bit = a_q[0] ^ b_q[0] ^ borrow_q;
    b_out = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bor_d    = bor_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = {d_bit, res_q[WIDTH-1:1]};
        borrow_d = b_out;
        // The final bit goes straight into the output registers so diff/bor
        // only ever change together with the done pulse.
        if (cnt_q == LAST_BIT) begin
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bor_d   = b_out;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bor_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bor_q    <= bor_d;
      cnt_q    <= cnt_d;
    end
  end

  assign diff = diff_q;
  assign bor  = bor_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule
